// File: rtl/perceptron_trainer.sv
// On-line perceptron learning controller. Presents one labelled sample at a time to an
// external forward neuron, reads its response back, and nudges the weights/bias with the
// saturating perceptron rule. Also keeps miss and convergence statistics.
module perceptron_trainer #(
   parameter int unsigned PIPE_LAT  = 2,
   parameter int unsigned LR_SHIFT  = 2,
   parameter int unsigned BIAS_STEP = 1,
   parameter int unsigned W1_INIT   = 0,
   parameter int unsigned W2_INIT   = 0,
   parameter int unsigned B_INIT    = 0,
   parameter int unsigned CONV_RUN  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_x1,
   input  logic [7:0]  s_x2,
   input  logic        s_target,
   output logic [7:0]  input1,
   output logic [7:0]  input2,
   output logic [7:0]  weight1,
   output logic [7:0]  weight2,
   output logic [7:0]  bias,
   input  logic [15:0] neuron_out,
   output logic        r_valid,
   output logic        r_pred,
   output logic        r_miss,
   output logic [15:0] err_count,
   output logic        converged,
   input  logic        clear_stats
);

   localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PIPE_LAT - 1);
   localparam logic [15:0] RUN_MAX = 16'(CONV_RUN);
   localparam logic [7:0] BSTEP = 8'(BIAS_STEP);

   typedef enum logic [1:0] {StIdle, StDrive, StEval, StUpdate} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            target_q;
   logic            y_q;
   logic            miss_q;
   logic [15:0]     run_q;
   logic            take;
   logic [7:0]      dx1, dx2;
   logic [7:0]      w1_upd, w2_upd, b_upd;
   logic [15:0]     run_inc;

   // Add/subtract at 9 bits, then clamp to the 8-bit unsigned range.
   function automatic logic [7:0] step_up(input logic [7:0] v, input logic [7:0] d);
      logic [8:0] s;
      s = {1'b0, v} + {1'b0, d};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [7:0] step_dn(input logic [7:0] v, input logic [7:0] d);
      logic [8:0] s;
      s = {1'b0, v} - {1'b0, d};
      return s[8] ? 8'h00 : s[7:0];
   endfunction

   assign take   = (state_q == StIdle) && s_valid;
   assign r_pred = y_q;
   assign r_miss = miss_q;

   // State register and DRIVE down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic plus handshake/result strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_ready = 1'b0;
      r_valid = 1'b0;
      case (state_q)
         StIdle: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_d = StDrive;
               cnt_d   = CNT_LOAD;
            end
         end
         StDrive: begin
            if (cnt_q == '0) begin
               state_d = StEval;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StEval: begin
            state_d = StUpdate;
         end
         StUpdate: begin
            r_valid = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Candidate weights/bias for a misclassified sample, direction chosen by the target.
   always_comb begin
      dx1    = input1 >> LR_SHIFT;
      dx2    = input2 >> LR_SHIFT;
      w1_upd = weight1;
      w2_upd = weight2;
      b_upd  = bias;
      if (target_q) begin
         w1_upd = step_up(weight1, dx1);
         w2_upd = step_up(weight2, dx2);
         b_upd  = step_up(bias, BSTEP);
      end else begin
         w1_upd = step_dn(weight1, dx1);
         w2_upd = step_dn(weight2, dx2);
         b_upd  = step_dn(bias, BSTEP);
      end
   end

   // Sample latch, neuron readback and weight/bias registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         input1   <= 8'h00;
         input2   <= 8'h00;
         target_q <= 1'b0;
         y_q      <= 1'b0;
         miss_q   <= 1'b0;
         weight1  <= 8'(W1_INIT);
         weight2  <= 8'(W2_INIT);
         bias     <= 8'(B_INIT);
      end else begin
         if (take) begin
            input1   <= s_x1;
            input2   <= s_x2;
            target_q <= s_target;
         end
         if (state_q == StEval) begin
            y_q    <= |neuron_out;
            miss_q <= (|neuron_out) != target_q;
         end
         if ((state_q == StUpdate) && miss_q) begin
            weight1 <= w1_upd;
            weight2 <= w2_upd;
            bias    <= b_upd;
         end
      end
   end

   // Saturating run length of consecutive hits.
   always_comb begin
      run_inc = (run_q >= RUN_MAX) ? run_q : run_q + 16'd1;
   end

   // Miss count, run counter and convergence flag; a clear overrides a same-cycle update.
   always_ff @(posedge clk) begin
      if (reset || clear_stats) begin
         err_count <= 16'h0000;
         run_q     <= 16'h0000;
         converged <= 1'b0;
      end else if (state_q == StUpdate) begin
         if (miss_q) begin
            err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            run_q     <= 16'h0000;
            converged <= 1'b0;
         end else begin
            run_q <= run_inc;
            if (run_inc == RUN_MAX) begin
               converged <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: directed opening samples, then randomized
// samples against a behavioural model of the learning rule, then a mid-DRIVE reset.
module tb_perceptron_trainer;

   localparam int unsigned PL  = 2;
   localparam int unsigned LS  = 2;
   localparam int unsigned BS  = 1;
   localparam int unsigned W1I = 0;
   localparam int unsigned W2I = 0;
   localparam int unsigned BI  = 0;
   localparam int unsigned CR  = 4;

   logic        clk;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_x1, s_x2;
   logic        s_target;
   logic [7:0]  input1, input2, weight1, weight2, bias;
   logic [15:0] neuron_out;
   logic        r_valid, r_pred, r_miss;
   logic [15:0] err_count;
   logic        converged;
   logic        clear_stats;

   // Neuron stand-in: either a forced response or a 2-stage forward model
   logic        force_mode;
   logic [15:0] neuron_drv;
   int          s1;
   logic [15:0] s2;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model of trainer state
   int m_w1, m_w2, m_b, m_err, m_run;
   bit m_conv;

   perceptron_trainer #(
      .PIPE_LAT (PL),
      .LR_SHIFT (LS),
      .BIAS_STEP(BS),
      .W1_INIT  (W1I),
      .W2_INIT  (W2I),
      .B_INIT   (BI),
      .CONV_RUN (CR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_x1       (s_x1),
      .s_x2       (s_x2),
      .s_target   (s_target),
      .input1     (input1),
      .input2     (input2),
      .weight1    (weight1),
      .weight2    (weight2),
      .bias       (bias),
      .neuron_out (neuron_out),
      .r_valid    (r_valid),
      .r_pred     (r_pred),
      .r_miss     (r_miss),
      .err_count  (err_count),
      .converged  (converged),
      .clear_stats(clear_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forward neuron: weighted sum, then a squashing stage that is nonzero iff the sum is
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 0;
         s2 <= 16'h0000;
      end else begin
         s1 <= int'(input1) * int'(weight1) + int'(input2) * int'(weight2) + int'(bias);
         s2 <= (s1 != 0) ? 16'h00FF : 16'h0000;
      end
   end

   assign neuron_out = force_mode ? neuron_drv : s2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int clip(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   task automatic model_reset();
      m_w1 = W1I; m_w2 = W2I; m_b = BI;
      m_err = 0; m_run = 0; m_conv = 0;
   endtask

   task automatic model_apply(input int x1, input int x2, input bit t, input bit miss,
                              input bit clr);
      if (miss) begin
         if (t) begin
            m_w1 = clip(m_w1 + (x1 >> LS));
            m_w2 = clip(m_w2 + (x2 >> LS));
            m_b  = clip(m_b + BS);
         end else begin
            m_w1 = clip(m_w1 - (x1 >> LS));
            m_w2 = clip(m_w2 - (x2 >> LS));
            m_b  = clip(m_b - BS);
         end
         if (m_err < 65535) m_err++;
         m_run  = 0;
         m_conv = 0;
      end else begin
         if (m_run < CR) m_run++;
         if (m_run == CR) m_conv = 1;
      end
      if (clr) begin
         m_err = 0; m_run = 0; m_conv = 0;
      end
   endtask

   task automatic check_state(input string pfx);
      check({pfx, "_ready"}, 32'(s_ready), 32'd1);
      check({pfx, "_w1"}, 32'(weight1), 32'(m_w1));
      check({pfx, "_w2"}, 32'(weight2), 32'(m_w2));
      check({pfx, "_bias"}, 32'(bias), 32'(m_b));
      check({pfx, "_err"}, 32'(err_count), 32'(m_err));
      check({pfx, "_conv"}, 32'(converged), 32'(m_conv));
   endtask

   // Called at #1 after an edge with the trainer idle; returns at #1 in the next idle cycle.
   task automatic do_sample(input logic [7:0] x1, input logic [7:0] x2, input bit t,
                            input bit fmode, input bit fy, input bit clr);
      bit exp_y, exp_miss;
      int lat;
      check("pre_ready", 32'(s_ready), 32'd1);
      s_valid    = 1'b1;
      s_x1       = x1;
      s_x2       = x2;
      s_target   = t;
      force_mode = fmode;
      if (fmode) begin
         neuron_drv = fy ? 16'($urandom_range(1, 65535)) : 16'h0000;
         exp_y      = fy;
      end else begin
         exp_y = (int'(x1) * m_w1 + int'(x2) * m_w2 + m_b) != 0;
      end
      exp_miss = exp_y != t;
      @(posedge clk); #1;
      check("in1", 32'(input1), 32'(x1));
      check("in2", 32'(input2), 32'(x2));
      // s_valid stays high with junk features while busy
      s_x1     = 8'($urandom);
      s_x2     = 8'($urandom);
      s_target = 1'($urandom);
      lat = 1;
      while (!r_valid && lat < 20) begin
         check("busy_ready", 32'(s_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(PL + 2));
      check("rvalid", 32'(r_valid), 32'd1);
      check("pred", 32'(r_pred), 32'(exp_y));
      check("miss", 32'(r_miss), 32'(exp_miss));
      clear_stats = clr;
      model_apply(int'(x1), int'(x2), t, exp_miss, clr);
      @(posedge clk); #1;
      clear_stats = 1'b0;
      check("rvalid_pulse", 32'(r_valid), 32'd0);
      check_state("post");
   endtask

   // Idle gap with s_valid low, optionally pulsing clear_stats.
   task automatic do_gap(input bit clr);
      s_valid     = 1'b0;
      clear_stats = clr;
      @(posedge clk); #1;
      clear_stats = 1'b0;
      if (clr) begin
         m_err = 0; m_run = 0; m_conv = 0;
      end
      check_state("gap");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit t, fy, saw_rv;
      reset       = 1'b1;
      s_valid     = 1'b0;
      s_x1        = 8'h00;
      s_x2        = 8'h00;
      s_target    = 1'b0;
      clear_stats = 1'b0;
      force_mode  = 1'b1;
      neuron_drv  = 16'h0000;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_ready", 32'(s_ready), 32'd1);
      check("rst_in1", 32'(input1), 32'd0);
      check("rst_in2", 32'(input2), 32'd0);
      check("rst_rvalid", 32'(r_valid), 32'd0);
      check("rst_rpred", 32'(r_pred), 32'd0);
      check("rst_rmiss", 32'(r_miss), 32'd0);
      check_state("rst");
      reset = 1'b0;

      // Forced y=0 with target 1 grows the weights; real neuron then sees sum>0 against t=0
      do_sample(8'd40, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t1_w1", 32'(weight1), 32'd10);
      check("t1_w2", 32'(weight2), 32'd2);
      check("t1_err", 32'(err_count), 32'd1);
      do_sample(8'd40, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_w1", 32'(weight1), 32'd0);
      check("t2_bias", 32'(bias), 32'd0);

      // Five hits then a miss: converged after the 4th hit, dropped on the miss
      do_gap(1'b1);
      for (int i = 0; i < 5; i++) begin
         t = 1'($urandom);
         do_sample(8'($urandom), 8'($urandom), t, 1'b1, t, 1'b0);
         check("t4_conv", 32'(converged), (i >= 3) ? 32'd1 : 32'd0);
      end
      do_sample(8'd200, 8'd100, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_conv_drop", 32'(converged), 32'd0);
      check("t4_err", 32'(err_count), 32'd1);

      // Randomized traffic; forced responses mostly agree with the target
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) do_gap($urandom_range(0, 2) == 0);
         t = 1'($urandom);
         fy = ($urandom_range(0, 3) == 0) ? !t : t;
         do_sample(8'($urandom), 8'($urandom), t, 1'($urandom), fy,
                   $urandom_range(0, 15) == 0);
      end

      // Reset during the second DRIVE cycle of a pending miss
      do_sample(8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0);
      s_valid  = 1'b1;
      s_x1     = 8'd255;
      s_x2     = 8'd255;
      s_target = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      check("t5_in1", 32'(input1), 32'd0);
      check_state("t5");
      saw_rv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (r_valid) saw_rv = 1'b1;
         @(posedge clk); #1;
      end
      check("t5_no_rvalid", 32'(saw_rv), 32'd0);
      check_state("t5_after");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
